rtmq_inst_fetch: RTL and testbench

Instruction fetch stage of the RTMQ core, directly upstream of the main memory A port. It owns the program counter and drives the A-port address and clock enable. It tracks the fixed 3-cycle A-port read latency with a tag pipeline, so every word returned on `dat_a` leaves the block with the matching PC and a valid flag. It supports downstream stall, jump-with-flush, and halt.

---
 rtl/rtmq_pkg.sv | 29 ++
 rtl/rtmq_tag_pipe.sv | 40 ++++
 rtl/rtmq_inst_fetch.sv | 111 +++++++++++
 tb/tb_rtmq_inst_fetch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtmq_pkg.sv
// Shared RTMQ definitions: register/address width, main-memory geometry,
// A-port read latency and the fetch-stage state encoding.
package rtmq_pkg;

    localparam int W_REG = 32;
    localparam int N_MEM = 256;
    localparam int L_MEM = 3;
    localparam int W_ADR = $clog2(N_MEM);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } if_state_t;

    typedef struct packed {
        logic             vld;
        logic [W_REG-1:0] pc;
    } tag_t;

    // Addresses live modulo the memory depth.
    function automatic logic [W_REG-1:0] mem_wrap(input logic [W_REG-1:0] adr);
        return adr & W_REG'(N_MEM - 1);
    endfunction

    function automatic logic adr_in_range(input logic [W_REG-1:0] adr);
        return (adr & ~W_REG'(N_MEM - 1)) == '0;
    endfunction

endpackage

// File: rtl/rtmq_tag_pipe.sv
// Enable-gated shift register of {valid, pc} tags shadowing the A-port read
// pipeline, with a synchronous flush and asynchronous reset.
module rtmq_tag_pipe
    import rtmq_pkg::*;
#(
    parameter int DEPTH = L_MEM
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [DEPTH];

    // Flush empties every stage; stage 0 still captures the new tag when the
    // memory is enabled in the same cycle (jump), otherwise it clears too (halt).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            stage_q[0] <= en ? tag_in : '0;
        end else if (en) begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/rtmq_inst_fetch.sv
// RTMQ instruction fetch: owns the PC, drives the main-memory A port and tags
// returning words with their PC. Define RTMQ_IF_FCNT_EN to add the fetch counter.
module rtmq_inst_fetch
    import rtmq_pkg::*;
#(
    parameter logic [W_REG-1:0] RST_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [W_REG-1:0] adr_a,
    output logic             en_a,
    input  logic [W_REG-1:0] dat_a,
    input  logic             stall,
    input  logic             jmp,
    input  logic [W_REG-1:0] jmp_adr,
    input  logic             hlt,
    output logic [W_REG-1:0] ins,
    output logic [W_REG-1:0] ins_pc,
    output logic             ins_vld,
    output logic             err,
    output if_state_t        dbg_state
`ifdef RTMQ_IF_FCNT_EN
    ,
    output logic [W_REG-1:0] fcnt
`endif
);

    // Handshake: ins/ins_pc carry a live instruction while ins_vld is high; it
    // is consumed in a cycle with ins_vld & ~stall, and held unchanged otherwise.

    if_state_t        state_q;
    if_state_t        state_d;
    logic [W_REG-1:0] pc_q;
    logic [W_REG-1:0] tgt;
    logic             jmp_bad;
    logic             halt_entry;
    logic             flush;
    tag_t             tag_s0;
    tag_t             tag_s2;

    always_comb begin
        jmp_bad    = ~adr_in_range(jmp_adr);
        tgt        = jmp_bad ? '0 : jmp_adr;
        adr_a      = jmp ? tgt : pc_q;
        en_a       = ~rst & (jmp | ((state_q == ST_RUN) & ~stall & ~hlt));
        halt_entry = (state_q == ST_RUN) & hlt & ~jmp;
        flush      = jmp | halt_entry;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (hlt && !jmp) state_d = ST_HALT;
            ST_HALT: if (jmp)         state_d = ST_RUN;
            default:                  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RST_PC;
        end else if (en_a) begin
            pc_q <= mem_wrap(adr_a + W_REG'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (jmp && jmp_bad) begin
            err <= 1'b1;
        end
    end

    assign tag_s0 = '{vld: 1'b1, pc: adr_a};

    rtmq_tag_pipe #(
        .DEPTH (L_MEM)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .en      (en_a),
        .flush   (flush),
        .tag_in  (tag_s0),
        .tag_out (tag_s2)
    );

    assign ins       = dat_a;
    assign ins_vld   = tag_s2.vld;
    assign ins_pc    = tag_s2.pc;
    assign dbg_state = state_q;

`ifdef RTMQ_IF_FCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
        end else if (ins_vld && !stall) begin
            fcnt <= fcnt + W_REG'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rtmq_inst_fetch.sv
// Self-checking bench for rtmq_inst_fetch with a 3-cycle enabled memory model.
module tb_rtmq_inst_fetch;
  import rtmq_pkg::*;

  logic             clk;
  logic             rst;
  logic [W_REG-1:0] adr_a;
  logic             en_a;
  logic [W_REG-1:0] dat_a;
  logic             stall;
  logic             jmp;
  logic [W_REG-1:0] jmp_adr;
  logic             hlt;
  logic [W_REG-1:0] ins;
  logic [W_REG-1:0] ins_pc;
  logic             ins_vld;
  logic             err;
  if_state_t        dbg_state;
`ifdef RTMQ_IF_FCNT_EN
  logic [W_REG-1:0] fcnt;
`endif

  int total = 0;
  int bad   = 0;

  rtmq_inst_fetch #(.RST_PC('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .adr_a     (adr_a),
    .en_a      (en_a),
    .dat_a     (dat_a),
    .stall     (stall),
    .jmp       (jmp),
    .jmp_adr   (jmp_adr),
    .hlt       (hlt),
    .ins       (ins),
    .ins_pc    (ins_pc),
    .ins_vld   (ins_vld),
    .err       (err),
    .dbg_state (dbg_state)
`ifdef RTMQ_IF_FCNT_EN
    ,
    .fcnt      (fcnt)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // main memory A port: read data appears after 3 enabled cycles, holds otherwise
  logic [W_REG-1:0] mem [N_MEM];
  logic [W_REG-1:0] rd_pipe [L_MEM];
  always @(posedge clk) begin
    if (en_a) begin
      rd_pipe[0] <= mem[adr_a[W_ADR-1:0]];
      for (int i = 1; i < L_MEM; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign dat_a = rd_pipe[L_MEM-1];

  function automatic logic [W_REG-1:0] wrap(input logic [W_REG-1:0] a);
    return a % W_REG'(N_MEM);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; jmp = 1'b0; hlt = 1'b0; jmp_adr = '0;
    repeat (2) tick();
    @(negedge clk);
    total++; if (ins_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0b want=0", ins_vld); end
    total++; if (ins_pc !== '0) begin bad++; $display("FAIL rst_pc got=%0h want=0", ins_pc); end
    total++; if (en_a !== 1'b0) begin bad++; $display("FAIL rst_en got=%0b want=0", en_a); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", err); end
`ifdef RTMQ_IF_FCNT_EN
    total++; if (fcnt !== '0) begin bad++; $display("FAIL rst_fcnt got=%0d want=0", fcnt); end
`endif
    tick();
    rst = 1'b0;
  endtask

  // sequential stream from reset release with a stall over cycles 5..8
  task automatic test_stream();
    logic [W_REG-1:0] cons;
    logic             exp_vld;
    cons = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      stall = (cyc >= 5 && cyc <= 8);
      @(negedge clk);
      exp_vld = (cyc >= 3);
      if (cyc == 0) begin
        total++; if (adr_a !== '0) begin bad++; $display("FAIL first_adr got=%0h want=0", adr_a); end
      end
      total++; if (en_a !== !stall) begin bad++; $display("FAIL seq_en cyc=%0d got=%0b want=%0b", cyc, en_a, !stall); end
      total++; if (ins_vld !== exp_vld) begin bad++; $display("FAIL seq_vld cyc=%0d got=%0b want=%0b", cyc, ins_vld, exp_vld); end
      if (exp_vld) begin
        total++; if (ins_pc !== cons) begin bad++; $display("FAIL seq_pc cyc=%0d got=%0h want=%0h", cyc, ins_pc, cons); end
        total++; if (ins !== mem[cons[W_ADR-1:0]]) begin bad++; $display("FAIL seq_ins cyc=%0d got=%0h want=%0h", cyc, ins, mem[cons[W_ADR-1:0]]); end
      end
`ifdef RTMQ_IF_FCNT_EN
      total++; if (fcnt !== cons) begin bad++; $display("FAIL seq_fcnt cyc=%0d got=%0d want=%0d", cyc, fcnt, cons); end
`endif
      if (exp_vld && !stall) cons = cons + 1;
      tick();
    end
    stall = 1'b0;
  endtask

  // jumps: 4, then 0x40 while ins_pc = 7, then near the top of memory to wrap
  task automatic test_jump();
    logic [W_REG-1:0] tg [3];
    logic [W_REG-1:0] exp_pc;
    tg[0] = 32'h4; tg[1] = 32'h40; tg[2] = W_REG'(N_MEM - 2);
    stall = 1'b0;
    for (int t = 0; t < 3; t++) begin
      jmp = 1'b1; jmp_adr = tg[t];
      @(negedge clk);
      total++; if (adr_a !== tg[t]) begin bad++; $display("FAIL jmp_adr got=%0h want=%0h", adr_a, tg[t]); end
      total++; if (en_a !== 1'b1) begin bad++; $display("FAIL jmp_en got=%0b want=1", en_a); end
      if (t > 0) begin
        exp_pc = wrap(tg[t-1] + 3);
        total++; if (ins_vld !== 1'b1 || ins_pc !== exp_pc) begin bad++; $display("FAIL jmp_pre_pc got=%0b/%0h want=1/%0h", ins_vld, ins_pc, exp_pc); end
      end
      tick();
      jmp = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        total++; if (ins_vld !== (k >= 3)) begin bad++; $display("FAIL jmp_vld k=%0d got=%0b want=%0b", k, ins_vld, (k >= 3)); end
        if (k >= 3) begin
          exp_pc = wrap(tg[t] + W_REG'(k - 3));
          total++; if (ins_pc !== exp_pc) begin bad++; $display("FAIL jmp_pc k=%0d got=%0h want=%0h", k, ins_pc, exp_pc); end
          total++; if (ins !== mem[exp_pc[W_ADR-1:0]]) begin bad++; $display("FAIL jmp_ins k=%0d got=%0h want=%0h", k, ins, mem[exp_pc[W_ADR-1:0]]); end
        end
        tick();
      end
    end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL jmp_err got=%0b want=0", err); end
    tick();
  endtask

  task automatic test_err();
    jmp = 1'b1; jmp_adr = W_REG'(N_MEM + 5);
    @(negedge clk);
    total++; if (adr_a !== '0) begin bad++; $display("FAIL err_adr got=%0h want=0", adr_a); end
    tick();
    jmp = 1'b0; jmp_adr = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky k=%0d got=%0b want=1", k, err); end
      if (k >= 3) begin
        total++; if (ins_vld !== 1'b1 || ins_pc !== W_REG'(k - 3)) begin bad++; $display("FAIL err_pc k=%0d got=%0b/%0h want=1/%0h", k, ins_vld, ins_pc, k - 3); end
      end
      tick();
    end
  endtask

  task automatic test_halt();
    hlt = 1'b1;
    @(negedge clk);
    total++; if (en_a !== 1'b0) begin bad++; $display("FAIL hlt_en0 got=%0b want=0", en_a); end
    tick();
    hlt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (en_a !== 1'b0 || ins_vld !== 1'b0) begin bad++; $display("FAIL hlt_idle k=%0d got=%0b/%0b want=0/0", k, en_a, ins_vld); end
      if (k == 0) begin
        total++; if (dbg_state !== ST_HALT) begin bad++; $display("FAIL hlt_state got=%0d want=%0d", dbg_state, ST_HALT); end
      end
      tick();
    end
    jmp = 1'b1; jmp_adr = 32'h10;
    @(negedge clk);
    total++; if (en_a !== 1'b1 || adr_a !== 32'h10) begin bad++; $display("FAIL hlt_jmp got=%0b/%0h want=1/10", en_a, adr_a); end
    tick();
    jmp = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++; if (ins_vld !== (k >= 3)) begin bad++; $display("FAIL hlt_resume_vld k=%0d got=%0b want=%0b", k, ins_vld, (k >= 3)); end
      if (k == 3) begin
        total++; if (ins_pc !== 32'h10) begin bad++; $display("FAIL hlt_resume_pc got=%0h want=10", ins_pc); end
      end
      tick();
    end
    // jump wins over a simultaneous halt
    jmp = 1'b1; hlt = 1'b1; jmp_adr = 32'h20;
    @(negedge clk);
    total++; if (en_a !== 1'b1 || adr_a !== 32'h20) begin bad++; $display("FAIL both_jmp got=%0b/%0h want=1/20", en_a, adr_a); end
    tick();
    jmp = 1'b0; hlt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++; if (en_a !== 1'b1) begin bad++; $display("FAIL both_en k=%0d got=%0b want=1", k, en_a); end
      if (k >= 3) begin
        total++; if (ins_vld !== 1'b1 || ins_pc !== W_REG'(32'h20 + k - 3)) begin bad++; $display("FAIL both_pc k=%0d got=%0b/%0h want=1/%0h", k, ins_vld, ins_pc, 32'h20 + k - 3); end
      end
      tick();
    end
  endtask

  // random stall/jump/halt against a consumed-stream reference model
  task automatic test_random();
    logic [W_REG-1:0] exp_next;
    logic [W_REG-1:0] prev_pc;
    logic [W_REG-1:0] prev_ins;
    logic [W_REG-1:0] tg;
    logic             halted;
    logic             prev_hold;
    logic             err_exp;
    logic             exp_en;
    int               n_cons;
    halted = 1'b0; prev_hold = 1'b0; err_exp = 1'b1; n_cons = 0;
    exp_next = '0; prev_pc = '0; prev_ins = '0;
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 99) < 30);
      hlt   = ($urandom_range(0, 99) < 3);
      jmp   = (n == 0) || ($urandom_range(0, 99) < 5) || (halted && $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) jmp_adr = W_REG'(N_MEM + $urandom_range(0, 63));
      else jmp_adr = W_REG'($urandom_range(0, N_MEM - 1));
      tg = (jmp_adr < W_REG'(N_MEM)) ? jmp_adr : '0;
      @(negedge clk);
      exp_en = jmp | (!halted & !stall & !hlt);
      total++; if (en_a !== exp_en) begin bad++; $display("FAIL rnd_en n=%0d got=%0b want=%0b", n, en_a, exp_en); end
      if (jmp) begin
        total++; if (adr_a !== tg) begin bad++; $display("FAIL rnd_adr n=%0d got=%0h want=%0h", n, adr_a, tg); end
      end
      total++; if (err !== err_exp) begin bad++; $display("FAIL rnd_err n=%0d got=%0b want=%0b", n, err, err_exp); end
      if (halted) begin
        total++; if (ins_vld !== 1'b0) begin bad++; $display("FAIL rnd_halt_vld n=%0d got=%0b want=0", n, ins_vld); end
      end
      if (prev_hold) begin
        total++; if (ins_vld !== 1'b1 || ins_pc !== prev_pc || ins !== prev_ins) begin bad++; $display("FAIL rnd_hold n=%0d got=%0b/%0h/%0h want=1/%0h/%0h", n, ins_vld, ins_pc, ins, prev_pc, prev_ins); end
      end
      if (ins_vld === 1'b1 && !stall) begin
        total++; if (ins_pc !== exp_next || ins !== mem[exp_next[W_ADR-1:0]]) begin bad++; $display("FAIL rnd_cons n=%0d got=%0h/%0h want=%0h/%0h", n, ins_pc, ins, exp_next, mem[exp_next[W_ADR-1:0]]); end
        exp_next = wrap(exp_next + 1);
        n_cons++;
      end
      prev_hold = (ins_vld === 1'b1) && stall && !jmp && !hlt;
      prev_pc = ins_pc; prev_ins = ins;
      if (jmp) begin
        if (jmp_adr >= W_REG'(N_MEM)) err_exp = 1'b1;
        exp_next = tg;
        halted = 1'b0;
      end else if (hlt) begin
        halted = 1'b1;
      end
      tick();
    end
    total++; if (n_cons < 50) begin bad++; $display("FAIL rnd_liveness got=%0d want>=50", n_cons); end
    stall = 1'b0; hlt = 1'b0; jmp = 1'b1; jmp_adr = 32'h30;
    tick();
    jmp = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    total++; if (ins_vld !== 1'b1 || ins_pc !== 32'h30) begin bad++; $display("FAIL rnd_final got=%0b/%0h want=1/30", ins_vld, ins_pc); end
    tick();
  endtask

  task automatic test_mid_reset();
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total++; if (ins_vld !== 1'b0 || ins_pc !== '0) begin bad++; $display("FAIL mrst_out got=%0b/%0h want=0/0", ins_vld, ins_pc); end
    total++; if (en_a !== 1'b0) begin bad++; $display("FAIL mrst_en got=%0b want=0", en_a); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mrst_err got=%0b want=0", err); end
    total++; if (dbg_state !== ST_RUN) begin bad++; $display("FAIL mrst_state got=%0d want=%0d", dbg_state, ST_RUN); end
`ifdef RTMQ_IF_FCNT_EN
    total++; if (fcnt !== '0) begin bad++; $display("FAIL mrst_fcnt got=%0d want=0", fcnt); end
`endif
    tick();
    rst = 1'b0; stall = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++; if (en_a !== 1'b1 || adr_a !== '0) begin bad++; $display("FAIL mrst_first got=%0b/%0h want=1/0", en_a, adr_a); end
      end
      total++; if (ins_vld !== (k >= 3)) begin bad++; $display("FAIL mrst_vld k=%0d got=%0b want=%0b", k, ins_vld, (k >= 3)); end
      if (k >= 3) begin
        total++; if (ins_pc !== W_REG'(k - 3) || ins !== mem[k - 3]) begin bad++; $display("FAIL mrst_pc k=%0d got=%0h/%0h want=%0h/%0h", k, ins_pc, ins, k - 3, mem[k - 3]); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jmp = 1'b0; hlt = 1'b0; jmp_adr = '0;
    for (int i = 0; i < N_MEM; i++) mem[i] = $urandom;
    #1;
    test_reset();
    test_stream();
    test_jump();
    test_err();
    test_halt();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
